// File: rtl/apb_slave_regfile.sv
// APB slave register bank with a programmable number of wait states.
//   PCLK / PRESETn   : clock, asynchronous active-low reset
//   PSEL/PENABLE/PWRITE/PADDR/PWDATA (_sl_i) : APB request from the master
//   WAIT_sl_i        : wait states for the next transfer, sampled at setup
//   PRDATA/PREADY/PSLVERR (_sl_o)            : registered APB response
// Index 0 is a read-only ID register. Indices >= DEPTH and writes to index 0
// complete with PSLVERR=1 and have no side effects.
module apb_slave_regfile #(
  parameter int unsigned           DATA_WIDTH = 32,
  parameter int unsigned           ADDR_WIDTH = 32,
  parameter int unsigned           DEPTH      = 16,
  parameter logic [DATA_WIDTH-1:0] ID_VALUE   = 32'hA5B0_0001
) (
  input  logic                  PCLK,
  input  logic                  PRESETn,
  input  logic                  PSEL_sl_i,
  input  logic                  PENABLE_sl_i,
  input  logic                  PWRITE_sl_i,
  input  logic [ADDR_WIDTH-1:0] PADDR_sl_i,
  input  logic [DATA_WIDTH-1:0] PWDATA_sl_i,
  input  logic [3:0]            WAIT_sl_i,
  output logic [DATA_WIDTH-1:0] PRDATA_sl_o,
  output logic                  PREADY_sl_o,
  output logic                  PSLVERR_sl_o
);

  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, READY = 2'd2} state_t;

  state_t                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  wr_q, wr_d, err_q, err_d;
  logic [DATA_WIDTH-1:0] prdata_d;
  logic                  pready_d, pslverr_d;

  // Index 0 is the ID constant, so only 1..DEPTH-1 are storage.
  logic [DEPTH-1:1][DATA_WIDTH-1:0] regs_q;

  logic                  setup, take_setup, commit, setup_err, go_ready;
  logic [ADDR_WIDTH-1:0] src_addr;
  logic                  src_wr, src_err;
  logic [DATA_WIDTH-1:0] rd_word, rd_data;

  assign setup      = PSEL_sl_i & ~PENABLE_sl_i;
  assign take_setup = setup && (state_q == IDLE || state_q == READY);
  assign commit     = (state_q == READY) && wr_q && !err_q;
  // Full-width unsigned compare: high index bits never alias onto a register.
  assign setup_err  = (PADDR_sl_i >= ADDR_WIDTH'(DEPTH)) ||
                      (PWRITE_sl_i && PADDR_sl_i == '0);

  // With zero wait states the response is loaded on the setup edge itself,
  // so the read source is the live bus; otherwise the latched request.
  assign src_addr = take_setup ? PADDR_sl_i  : addr_q;
  assign src_wr   = take_setup ? PWRITE_sl_i : wr_q;
  assign src_err  = take_setup ? setup_err   : err_q;

  always_comb begin
    rd_word = '0;
    for (int i = 1; i < DEPTH; i++)
      if (src_addr == ADDR_WIDTH'(i)) rd_word = regs_q[i];
    // A back-to-back read sampled on the edge that commits the previous
    // write must see the new value.
    if (commit && src_addr == addr_q) rd_word = wdata_q;
    if (src_wr || src_err)    rd_data = '0;
    else if (src_addr == '0)  rd_data = ID_VALUE;
    else                      rd_data = rd_word;
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wr_d      = wr_q;
    err_d     = err_q;
    prdata_d  = '0;
    pready_d  = 1'b0;
    pslverr_d = 1'b0;
    go_ready  = 1'b0;

    case (state_q)
      IDLE:  ;
      WAIT: begin
        if (!PSEL_sl_i) begin
          state_d = IDLE;               // master abandoned the transfer
        end else if (PENABLE_sl_i) begin
          if (cnt_q <= 4'd1) go_ready = 1'b1;
          else               cnt_d    = cnt_q - 4'd1;
        end
      end
      READY:   state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (take_setup) begin
      addr_d  = PADDR_sl_i;
      wdata_d = PWDATA_sl_i;
      wr_d    = PWRITE_sl_i;
      err_d   = setup_err;
      if (WAIT_sl_i == 4'd0) begin
        go_ready = 1'b1;
      end else begin
        cnt_d   = WAIT_sl_i;
        state_d = WAIT;
      end
    end

    if (go_ready) begin
      state_d   = READY;
      pready_d  = 1'b1;
      pslverr_d = src_err;
      prdata_d  = rd_data;
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      wr_q         <= 1'b0;
      err_q        <= 1'b0;
      PRDATA_sl_o  <= '0;
      PREADY_sl_o  <= 1'b0;
      PSLVERR_sl_o <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      wr_q         <= wr_d;
      err_q        <= err_d;
      PRDATA_sl_o  <= prdata_d;
      PREADY_sl_o  <= pready_d;
      PSLVERR_sl_o <= pslverr_d;
    end
  end

  // Writes land on the edge that leaves READY.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      regs_q <= '0;
    end else if (commit) begin
      for (int i = 1; i < DEPTH; i++)
        if (addr_q == ADDR_WIDTH'(i)) regs_q[i] <= wdata_q;
    end
  end

endmodule

// File: tb/tb_apb_slave_regfile.sv
// Self-checking bench for apb_slave_regfile: directed vector table, hand-written
// corner sequences (abort, back-to-back, reset mid-transfer) and randomized
// transfers checked against an array-based reference model.
module tb_apb_slave_regfile;
  localparam int          DEPTH = 16;
  localparam logic [31:0] ID    = 32'hA5B0_0001;
  localparam int          LAT_BUDGET = 24;

  logic        PCLK, PRESETn;
  logic        PSEL_sl_i, PENABLE_sl_i, PWRITE_sl_i;
  logic [31:0] PADDR_sl_i, PWDATA_sl_i;
  logic [3:0]  WAIT_sl_i;
  logic [31:0] PRDATA_sl_o;
  logic        PREADY_sl_o, PSLVERR_sl_o;

  apb_slave_regfile #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH(DEPTH), .ID_VALUE(ID)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .PSEL_sl_i(PSEL_sl_i), .PENABLE_sl_i(PENABLE_sl_i), .PWRITE_sl_i(PWRITE_sl_i),
    .PADDR_sl_i(PADDR_sl_i), .PWDATA_sl_i(PWDATA_sl_i), .WAIT_sl_i(WAIT_sl_i),
    .PRDATA_sl_o(PRDATA_sl_o), .PREADY_sl_o(PREADY_sl_o), .PSLVERR_sl_o(PSLVERR_sl_o)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached, got no summary required summary");
    $fatal(1, "watchdog");
  end

  int passed = 0;
  int total  = 0;

  logic [31:0] model [DEPTH];

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  w;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;
  vec_t tbl [13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic void predict(input logic wr, input logic [31:0] addr,
                                  output logic [31:0] rd, output logic err);
    err = (addr >= 32'(DEPTH)) || (wr && addr == 32'd0);
    if (wr || err)          rd = 32'd0;
    else if (addr == 32'd0) rd = ID;
    else                    rd = model[addr[3:0]];
  endfunction

  // Drives setup now (caller is at a negedge), then access until PREADY or budget.
  task automatic xfer(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                      input logic [3:0] w, output logic [31:0] rd, output logic err,
                      output int lat);
    PSEL_sl_i = 1'b1; PENABLE_sl_i = 1'b0; PWRITE_sl_i = wr;
    PADDR_sl_i = addr; PWDATA_sl_i = data; WAIT_sl_i = w;
    @(negedge PCLK);
    PENABLE_sl_i = 1'b1;
    // Bus contents during access must be ignored by the slave.
    PADDR_sl_i = ~addr; PWDATA_sl_i = ~data; WAIT_sl_i = ~w;
    lat = 1;
    while (!PREADY_sl_o && lat < LAT_BUDGET) begin
      @(negedge PCLK);
      lat++;
    end
    rd = PRDATA_sl_o; err = PSLVERR_sl_o;
  endtask

  task automatic idle();
    PSEL_sl_i = 1'b0; PENABLE_sl_i = 1'b0;
    @(negedge PCLK);
    chk("pready_one_cycle", {31'd0, PREADY_sl_o}, 32'd0);
  endtask

  task automatic run(input string tag, input logic wr, input logic [31:0] addr,
                     input logic [31:0] data, input logic [3:0] w,
                     input logic [31:0] exp_rd, input logic exp_err, input bit b2b);
    logic [31:0] rd; logic err; int lat;
    xfer(wr, addr, data, w, rd, err, lat);
    chk({tag, "_rdata"}, rd, exp_rd);
    chk({tag, "_err"}, {31'd0, err}, {31'd0, exp_err});
    chk({tag, "_latency"}, 32'(lat), 32'(w) + 32'd1);
    if (wr && !exp_err && addr < 32'(DEPTH)) model[addr[3:0]] = data;
    if (!b2b) idle();
  endtask

  initial begin
    logic [31:0] erd, addr, data;
    logic eerr, wr;
    logic [3:0] w;
    bit b2b;
    int sel;

    tbl[0]  = '{1'b0, 32'd0,          32'd0,          4'd0, ID,             1'b0};
    tbl[1]  = '{1'b1, 32'd5,          32'hDEAD_BEEF,  4'd0, 32'd0,          1'b0};
    tbl[2]  = '{1'b0, 32'd5,          32'd0,          4'd0, 32'hDEAD_BEEF,  1'b0};
    tbl[3]  = '{1'b0, 32'd5,          32'd0,          4'd3, 32'hDEAD_BEEF,  1'b0};
    tbl[4]  = '{1'b1, 32'd0,          32'h1111_1111,  4'd0, 32'd0,          1'b1};
    tbl[5]  = '{1'b0, 32'd0,          32'd0,          4'd1, ID,             1'b0};
    tbl[6]  = '{1'b0, 32'd16,         32'd0,          4'd0, 32'd0,          1'b1};
    tbl[7]  = '{1'b1, 32'd4,          32'hCAFE_0004,  4'd2, 32'd0,          1'b0};
    tbl[8]  = '{1'b1, 32'd20,         32'h0000_1234,  4'd0, 32'd0,          1'b1};
    tbl[9]  = '{1'b0, 32'd4,          32'd0,          4'd0, 32'hCAFE_0004,  1'b0};
    tbl[10] = '{1'b0, 32'hFFFF_FFFF,  32'd0,          4'd2, 32'd0,          1'b1};
    tbl[11] = '{1'b1, 32'd15,         32'h0F0F_0F0F,  4'd1, 32'd0,          1'b0};
    tbl[12] = '{1'b0, 32'd15,         32'd0,          4'd0, 32'h0F0F_0F0F,  1'b0};

    for (int i = 0; i < DEPTH; i++) model[i] = 32'd0;

    PRESETn = 1'b0; PSEL_sl_i = 1'b0; PENABLE_sl_i = 1'b0; PWRITE_sl_i = 1'b0;
    PADDR_sl_i = '0; PWDATA_sl_i = '0; WAIT_sl_i = '0;
    repeat (3) @(negedge PCLK);
    chk("reset_prdata",  PRDATA_sl_o, 32'd0);
    chk("reset_pready",  {31'd0, PREADY_sl_o}, 32'd0);
    chk("reset_pslverr", {31'd0, PSLVERR_sl_o}, 32'd0);
    PRESETn = 1'b1;
    idle();

    for (int i = 0; i < 13; i++)
      run($sformatf("tbl%0d", i), tbl[i].wr, tbl[i].addr, tbl[i].data, tbl[i].w,
          tbl[i].exp_rd, tbl[i].exp_err, 1'b0);

    // Access strobe with no preceding setup is ignored.
    PSEL_sl_i = 1'b1; PENABLE_sl_i = 1'b1; PADDR_sl_i = 32'd5; PWRITE_sl_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge PCLK);
      chk("no_setup_pready", {31'd0, PREADY_sl_o}, 32'd0);
    end
    idle();
    run("after_no_setup", 1'b0, 32'd5, 32'd0, 4'd0, model[5], 1'b0, 1'b0);

    // Back-to-back: read setup sampled on the edge that commits the write.
    run("b2b_wr", 1'b1, 32'd9, 32'hABCD_1234, 4'd0, 32'd0, 1'b0, 1'b1);
    run("b2b_rd", 1'b0, 32'd9, 32'd0,         4'd0, 32'hABCD_1234, 1'b0, 1'b1);
    run("b2b_rd_w2", 1'b0, 32'd4, 32'd0,      4'd2, 32'hCAFE_0004, 1'b0, 1'b0);

    // Master timeout: PSEL dropped after 5 access cycles of a 15-wait write.
    PSEL_sl_i = 1'b1; PENABLE_sl_i = 1'b0; PWRITE_sl_i = 1'b1;
    PADDR_sl_i = 32'd7; PWDATA_sl_i = 32'h7777_7777; WAIT_sl_i = 4'd15;
    @(negedge PCLK);
    PENABLE_sl_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge PCLK);
      chk($sformatf("abort_pready%0d", i), {31'd0, PREADY_sl_o}, 32'd0);
    end
    idle();
    idle();
    run("abort_rd7", 1'b0, 32'd7, 32'd0, 4'd0, model[7], 1'b0, 1'b0);
    run("abort_next", 1'b0, 32'd9, 32'd0, 4'd1, 32'hABCD_1234, 1'b0, 1'b0);

    b2b = 1'b0;
    for (int k = 0; k < 250; k++) begin
      wr  = 1'($urandom_range(0, 1));
      sel = int'($urandom_range(0, 9));
      if (sel < 8)       addr = $urandom_range(0, DEPTH + 2);
      else if (sel == 8) addr = $urandom;
      else               addr = 32'h0001_0000 | $urandom_range(0, 15);
      data = $urandom;
      w    = 4'($urandom_range(0, 5));
      b2b  = ($urandom_range(0, 3) == 0);
      predict(wr, addr, erd, eerr);
      run($sformatf("rnd%0d", k), wr, addr, data, w, erd, eerr, b2b);
    end
    if (b2b) idle();

    // Reset during the wait phase of a write.
    PSEL_sl_i = 1'b1; PENABLE_sl_i = 1'b0; PWRITE_sl_i = 1'b1;
    PADDR_sl_i = 32'd3; PWDATA_sl_i = 32'h3333_3333; WAIT_sl_i = 4'd5;
    @(negedge PCLK);
    PENABLE_sl_i = 1'b1;
    @(negedge PCLK);
    chk("rstw_pready_pre", {31'd0, PREADY_sl_o}, 32'd0);
    PRESETn = 1'b0;
    #1;
    chk("rstw_prdata",  PRDATA_sl_o, 32'd0);
    chk("rstw_pready",  {31'd0, PREADY_sl_o}, 32'd0);
    chk("rstw_pslverr", {31'd0, PSLVERR_sl_o}, 32'd0);
    for (int i = 0; i < DEPTH; i++) model[i] = 32'd0;
    PSEL_sl_i = 1'b0; PENABLE_sl_i = 1'b0;
    @(negedge PCLK);
    PRESETn = 1'b1;
    idle();
    run("rstw_rd3", 1'b0, 32'd3, 32'd0, 4'd0, 32'd0, 1'b0, 1'b0);

    // Reset while the response is on the bus clears it asynchronously.
    PSEL_sl_i = 1'b1; PENABLE_sl_i = 1'b0; PWRITE_sl_i = 1'b0;
    PADDR_sl_i = 32'd0; WAIT_sl_i = 4'd0;
    @(negedge PCLK);
    PENABLE_sl_i = 1'b1;
    chk("rstr_pready_pre", {31'd0, PREADY_sl_o}, 32'd1);
    chk("rstr_prdata_pre", PRDATA_sl_o, ID);
    PRESETn = 1'b0;
    #1;
    chk("rstr_pready", {31'd0, PREADY_sl_o}, 32'd0);
    chk("rstr_prdata", PRDATA_sl_o, 32'd0);
    PSEL_sl_i = 1'b0; PENABLE_sl_i = 1'b0;
    @(negedge PCLK);
    PRESETn = 1'b1;
    idle();
    run("post_rst_id", 1'b0, 32'd0, 32'd0, 4'd0, ID, 1'b0, 1'b0);
    run("post_rst_rd5", 1'b0, 32'd5, 32'd0, 4'd2, 32'd0, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/apb_slave_regfile.md
Name: apb_slave_regfile

Overview:
- APB slave register bank that sits directly downstream of apb_master and consumes its PSEL/PENABLE/PWRITE/PADDR/PWDATA.
- Returns PRDATA/PREADY/PSLVERR with a programmable number of wait states.
- Register 0 is a read-only ID register. Out-of-range addresses and writes to the ID register are flagged as errors.
- Serves as the bench and system target for exercising the master's DONE, FAIL and timeout paths.

Parameters:
- DATA_WIDTH, 32, width of PWDATA/PRDATA and of each register.
- ADDR_WIDTH, 32, width of PADDR. PADDR is a word index, not a byte address.
- DEPTH, 16, number of registers; valid indices are 0..DEPTH-1.
- ID_VALUE, 32'hA5B0_0001, constant returned when register 0 is read.

Ports:
- PCLK  input  1  APB clock; all state updates on the rising edge.
- PRESETn  input  1  asynchronous active-low reset.
- PSEL_sl_i  input  1  slave select.
- PENABLE_sl_i  input  1  access-phase strobe.
- PWRITE_sl_i  input  1  1 = write, 0 = read.
- PADDR_sl_i  input  ADDR_WIDTH  register index.
- PWDATA_sl_i  input  DATA_WIDTH  write data.
- WAIT_sl_i  input  4  number of wait states for the next transfer; sampled in the setup phase.
- PRDATA_sl_o  output  DATA_WIDTH  read data; valid when PREADY_sl_o=1.
- PREADY_sl_o  output  1  transfer completes in this cycle.
- PSLVERR_sl_o  output  1  error flag; valid only when PREADY_sl_o=1.

Behaviour:
- Reset and clocking: reset is PRESETn, asynchronous, active-low; clock is PCLK.
- Reset values: PRDATA_sl_o=0, PREADY_sl_o=0, PSLVERR_sl_o=0, state=IDLE, wait counter=0, registers 1..DEPTH-1 = 0.
- Reset asserted mid-transfer aborts the transfer immediately; no register write occurs.
- All outputs are registered.
- FSM states: IDLE, WAIT, READY.
- IDLE:
  - On an edge with PSEL=1 and PENABLE=0 (setup phase), latch PADDR/PWRITE/PWDATA and decode the error.
  - err = (PADDR >= DEPTH) or (PWRITE=1 and PADDR=0).
  - If WAIT_sl_i=0, go to READY. Else load cnt=WAIT_sl_i and go to WAIT.
  - An edge with PSEL=1 and PENABLE=1 without a preceding setup is ignored; state stays IDLE.
- WAIT:
  - Each edge with PSEL=1 and PENABLE=1 decrements cnt.
  - When cnt=1 at that edge, go to READY.
  - If PSEL=0 at any edge (master aborted on timeout), go to IDLE with no write; PREADY stays 0.
- READY (PREADY_sl_o=1 for exactly this cycle):
  - PSLVERR_sl_o=err.
  - PRDATA_sl_o = register[PADDR] for a good read; ID_VALUE for index 0; 0 for writes and errors.
  - PRDATA/PSLVERR are loaded on the same edge that enters READY.
  - At the edge leaving READY:
    - Commit the write if PWRITE=1 and err=0.
    - Clear PREADY, PSLVERR and PRDATA to 0.
    - If PSEL=1 and PENABLE=0 on this edge, treat it as a new setup (back-to-back transfer).
    - Otherwise go to IDLE.
- Latency: with N wait states, PREADY is high in access cycle N+1. N=0 gives zero-wait APB: PREADY in the first PENABLE cycle.
- Address and data are used as latched at setup; changes during access are ignored.
- A read of a register written in the immediately preceding transfer returns the new value.
- Out-of-range index compare is unsigned at full ADDR_WIDTH; there is no wrap-around or aliasing.

Test Plan:
- Reset: with PRESETn=0, all outputs are 0. After release, a read of index 0 with WAIT=0 returns PRDATA=32'hA5B0_0001, PREADY in the first access cycle, PSLVERR=0.
- Write/read, zero wait: write 32'hDEAD_BEEF to index 5, then read index 5 -> PRDATA=32'hDEAD_BEEF, PSLVERR=0. Each transfer completes in 2 cycles (setup + 1 access).
- Wait states: WAIT_sl_i=3, read index 5 -> PREADY=0 for 3 access cycles, then 1 on the 4th with the correct data; PREADY high for exactly 1 cycle.
- Errors: write to index 0 -> PSLVERR=1, ID unchanged. Read index 16 (DEPTH=16) -> PSLVERR=1, PRDATA=0. Write 32'h1234 to index 20, then read index 4 -> still old value (no aliasing).
- Abort: WAIT_sl_i=15 and PSEL dropped after 5 access cycles (master timeout) -> PREADY never asserted; the target register is unchanged; the next transfer completes normally.
- Reset mid-transfer: assert PRESETn=0 during WAIT of a write to index 3 -> outputs 0 immediately; index 3 reads 0 afterwards.
